// File: rtl/pipe_ctrl.sv
// Stage-register write-enable/clear sequencing for the five-stage MIPS32 pipe.
// Optional performance counters are compiled in with PIPE_CTRL_PERF_EN.
module pipe_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic        i_clk,
  input  logic        i_s_rst_n,
  input  logic [31:0] i_instr_ID,
  input  logic [31:0] i_instr_EX,
  input  logic        i_branch_taken_EX,
  input  logic        i_mem_req,
  input  logic        i_mem_ready,
  output logic        o_we_PC,
  output logic        o_we_ID,
  output logic        o_we_EX,
  output logic        o_we_MemAc,
  output logic        o_we_WrBc,
  output logic        o_flush_ID,
  output logic        o_flush_EX,
  output logic        o_flush_MemAc,
  output logic        o_flush_WrBc,
  output logic [1:0]  o_state,
  output logic        o_mem_err,
  output logic [15:0] o_stall_cnt,
  output logic [15:0] o_flush_cnt
);

  localparam int unsigned WAIT_W = 8;
  localparam int unsigned CNT_W  = 16;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_MEM_WAIT = 2'b01,
    ST_TIMEOUT  = 2'b10
  } state_e;

  state_e              state_q, state_d;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic                mem_err_q, mem_err_d;

  logic                mem_wait;
  logic                load_use;
  logic                id_reads_rt;
  logic [5:0]          id_op;
  logic [4:0]          ex_rt;

  // Hazard detection
  always_comb begin
    id_op       = i_instr_ID[31:26];
    ex_rt       = i_instr_EX[20:16];
    mem_wait    = i_mem_req & ~i_mem_ready;
    id_reads_rt = (id_op == OP_RTYPE) || (id_op == OP_SW) ||
                  (id_op == OP_BEQ)   || (id_op == OP_BNE);
    load_use    = (i_instr_EX[31:26] == OP_LW) && (ex_rt != 5'd0) &&
                  ((ex_rt == i_instr_ID[25:21]) ||
                   (id_reads_rt && (ex_rt == i_instr_ID[20:16])));
  end

  // Stage-register controls, priority reset > memory wait > branch > load-use
  always_comb begin
    o_we_PC       = 1'b1;
    o_we_ID       = 1'b1;
    o_we_EX       = 1'b1;
    o_we_MemAc    = 1'b1;
    o_we_WrBc     = 1'b1;
    o_flush_ID    = 1'b0;
    o_flush_EX    = 1'b0;
    o_flush_MemAc = 1'b0;
    o_flush_WrBc  = 1'b0;
    if (!i_s_rst_n) begin
      o_we_PC       = 1'b0;
      o_we_ID       = 1'b0;
      o_we_EX       = 1'b0;
      o_we_MemAc    = 1'b0;
      o_we_WrBc     = 1'b0;
      o_flush_ID    = 1'b1;
      o_flush_EX    = 1'b1;
      o_flush_MemAc = 1'b1;
      o_flush_WrBc  = 1'b1;
    end else if (mem_wait) begin
      o_we_PC    = 1'b0;
      o_we_ID    = 1'b0;
      o_we_EX    = 1'b0;
      o_we_MemAc = 1'b0;
      o_we_WrBc  = 1'b0;
    end else if (i_branch_taken_EX) begin
      o_flush_ID = 1'b1;
      o_flush_EX = 1'b1;
    end else if (load_use) begin
      o_we_PC    = 1'b0;
      o_we_ID    = 1'b0;
      o_flush_EX = 1'b1;
    end
  end

  // Memory-wait FSM; wait_cnt is zero in RUN, so the same compare covers MEM_TIMEOUT=1
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    mem_err_d  = mem_err_q;
    case (state_q)
      ST_RUN: begin
        if (mem_wait) begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
          if (wait_cnt_q == WAIT_LAST) begin
            state_d   = ST_TIMEOUT;
            mem_err_d = 1'b1;
          end else begin
            state_d = ST_MEM_WAIT;
          end
        end
      end
      ST_MEM_WAIT: begin
        if (i_mem_ready) begin
          state_d    = ST_RUN;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == WAIT_LAST) begin
          state_d   = ST_TIMEOUT;
          mem_err_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end
      ST_TIMEOUT: begin
        if (i_mem_ready) begin
          state_d    = ST_RUN;
          wait_cnt_d = '0;
        end
      end
      default: begin
        state_d    = ST_RUN;
        wait_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_s_rst_n) begin
      state_q    <= ST_RUN;
      wait_cnt_q <= '0;
      mem_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      mem_err_q  <= mem_err_d;
    end
  end

  assign o_state   = state_q;
  assign o_mem_err = mem_err_q;

`ifdef PIPE_CTRL_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             flush_apply;

  // Saturating stall and branch-flush counters
  always_comb begin
    flush_apply = i_branch_taken_EX & ~mem_wait;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!o_we_PC && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if (flush_apply && (flush_cnt_q != {CNT_W{1'b1}})) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_s_rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign o_stall_cnt = stall_cnt_q;
  assign o_flush_cnt = flush_cnt_q;
`else
  assign o_stall_cnt = CNT_W'(0);
  assign o_flush_cnt = CNT_W'(0);
`endif

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline sequencing controller for the five-stage MIPS32 core. Drives the write-enable and synchronous-clear inputs of every stage pipe register (PC, IF/ID, ID/EX, EX/MemAc, MemAc/WrBc) from hazard and memory-handshake inputs. It handles three cases: load-use stalls, taken-branch flushes, and freezes while data memory is not ready. A small FSM tracks memory waits and raises a sticky timeout error.

## Interface
- MEM_TIMEOUT, 16, number of consecutive not-ready wait cycles before the timeout state is entered. Legal range 1..255.
- i_clk  in  1  clock; all state updates on the rising edge.
- i_s_rst_n  in  1  reset, synchronous, active-low.
- i_instr_ID  in  32  instruction currently in decode.
- i_instr_EX  in  32  instruction currently in execute.
- i_branch_taken_EX  in  1  branch or jump in EX resolved taken.
- i_mem_req  in  1  instruction in MemAc accesses data memory this cycle.
- i_mem_ready  in  1  data memory completes the access this cycle.
- o_we_PC, o_we_ID, o_we_EX, o_we_MemAc, o_we_WrBc  out  1 each  stage register write enables.
- o_flush_ID, o_flush_EX, o_flush_MemAc, o_flush_WrBc  out  1 each  stage register synchronous clears (insert bubble).
- o_state  out  2  FSM state: 00 RUN, 01 MEM_WAIT, 10 TIMEOUT.
- o_mem_err  out  1  sticky timeout flag.
- o_stall_cnt  out  16  stall-cycle counter (see Configuration).
- o_flush_cnt  out  16  branch-flush counter (see Configuration).

## Operation
- Control outputs are combinational from the current inputs, so they take effect at the next edge. Only the FSM, wait counter, error flag and counters are registered.
- Priority when conditions coincide: reset > memory wait > branch flush > load-use.
- Memory wait is active when i_mem_req=1 and i_mem_ready=0. It drives all o_we_*=0 and all o_flush_*=0, freezing the whole pipe. Branch and load-use conditions are ignored while it is active and re-evaluated afterwards.
- Branch flush is active when i_branch_taken_EX=1. It drives o_flush_ID=1 and o_flush_EX=1, with all o_we_*=1.
- Load-use stall conditions:
  - EX opcode[31:26] = 100011 (lw) and EX rt[20:16] != 0.
  - That rt equals ID rs[25:21], or equals ID rt[20:16] when the ID opcode is 000000, 101011, 000100 or 000101.
- Load-use stall response: o_we_PC=0, o_we_ID=0, o_flush_EX=1. All other we=1 and all other flush=0.
- Default: all we=1, all flush=0.
- FSM transitions:
  - RUN -> MEM_WAIT when the memory wait condition holds.
  - MEM_WAIT -> RUN when i_mem_ready=1.
  - MEM_WAIT -> TIMEOUT when the wait counter reaches MEM_TIMEOUT-1 and ready is still 0. The 8-bit wait counter counts MEM_WAIT cycles, clears on entry to RUN, and holds in TIMEOUT.
  - TIMEOUT -> RUN when i_mem_ready=1.
- o_mem_err is set on entry to TIMEOUT and stays set until reset.
- The pipe stays frozen in TIMEOUT until i_mem_ready=1.
- A load-use stall lasts exactly one cycle: the flushed ID/EX register holds a nop next cycle, so the stall condition clears by itself.

## Timing
- Reset behaviour, while i_s_rst_n=0:
  - All o_we_*=0 and all o_flush_*=1.
  - After the edge: o_state=00, o_mem_err=0, wait counter=0, both counters=0.
  - Reset during MEM_WAIT or TIMEOUT returns to RUN on that edge.
- Zero-cycle latency from inputs to o_we_*/o_flush_*.
- o_state, o_mem_err and the counters reflect the conditions of the previous cycle.
- i_mem_req=1 with i_mem_ready=1 in the same cycle: no wait, state stays RUN.
- With MEM_TIMEOUT=1, TIMEOUT is entered after a single not-ready cycle.

## Configuration
- PIPE_CTRL_PERF_EN defined: performance counters are compiled in.
  - o_stall_cnt increments on every non-reset cycle with o_we_PC=0 (load-use stall or memory wait).
  - o_flush_cnt increments on every non-reset cycle in which a branch flush is applied.
  - Both counters saturate at 16'hFFFF and clear on reset.
- PIPE_CTRL_PERF_EN undefined: no counter logic; o_stall_cnt and o_flush_cnt are tied to 0.

## Test plan
- Load-use: EX=lw $8,0($9), ID=add $10,$8,$11 -> one cycle of o_we_PC=0, o_we_ID=0, o_flush_EX=1; the next cycle, with EX=nop, returns to all we=1. With PERF_EN, o_stall_cnt=1.
- Load to $0: EX=lw $0,0($9), ID=add $10,$0,$11 -> no stall, all we=1, all flush=0.
- Coincident events: load-use condition plus i_branch_taken_EX=1 -> o_flush_ID=1, o_flush_EX=1, all we=1, no stall. With PERF_EN, o_flush_cnt increments by 1.
- Memory wait: i_mem_req=1, i_mem_ready=0 for 3 cycles, then ready=1 -> all we=0 for 3 cycles and o_state=01 from the 2nd cycle. All we=1 on the ready cycle, and o_state=00 after the next edge.
- Timeout: MEM_TIMEOUT=4, ready held 0 -> o_state=10 and o_mem_err=1 after the 4th wait cycle. Ready=1 then returns to RUN, and o_mem_err stays 1.
- Reset mid-wait: i_s_rst_n=0 during TIMEOUT -> all flush=1 and all we=0 during reset. After the edge: o_state=00, o_mem_err=0, counters 0.
